eq_arbiter: RTL and testbench

EQ_ARBITER -- requirements
Module: eq_arbiter

---
 rtl/eq_arbiter.sv | 105 ++++++++++
 tb/tb_eq_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eq_arbiter.sv
// Two-requester arbiter sharing one external equality unit: IDLE grant -> CMP -> RSP, one compare in flight.
// Grant to rsp_valid is 2 cycles; rsp_ready low holds RSP and blocks all new grants until the handshake.
module eq_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_eq,
    output logic             rsp_valid,
    output logic             rsp_eq,
    output logic             rsp_id,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_q, eq_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             any_vld;
    logic             grant_id;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        any_vld  = req0_valid | req1_valid;
        grant_id = req1_valid & (~req0_valid | ~last_q);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        eq_d       = eq_q;
        id_d       = id_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps ready low while reset holds the FSM in IDLE.
                if (any_vld && rst_n) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    a_d        = grant_id ? req1_a : req0_a;
                    b_d        = grant_id ? req1_b : req0_b;
                    id_d       = grant_id;
                    last_d     = grant_id;
                    state_d    = CMP;
                end
            end
            CMP: begin
                eq_d    = cmp_eq;
                state_d = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign rsp_valid = (state_q == RSP);
    assign rsp_eq    = eq_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_eq_arbiter.sv
// Directed scenarios plus random traffic checked every cycle against a transaction-level model.
module tb_eq_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, cmp_a, cmp_b;
    logic         cmp_eq, rsp_valid, rsp_eq, rsp_id, rsp_ready;

    always #5 clk = ~clk;

    // Shared equality unit lives outside the arbiter.
    assign cmp_eq = (cmp_a == cmp_b);

    eq_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .rsp_valid(rsp_valid), .rsp_eq(rsp_eq), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Model: one job in flight; m_age counts cycles since its grant.
    bit           m_busy;
    int           m_age;
    bit           m_id, m_eq, m_last;
    logic [W-1:0] m_a, m_b;

    int obs_g[$], obs_gt[$], obs_rsp[$], obs_rt[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_id = 0; m_eq = 0; m_last = 1; m_a = '0; m_b = '0;
    endtask

    task automatic model_pick(output bit gv, output bit gid);
        gv = req0_valid || req1_valid;
        if (req0_valid && req1_valid) gid = !m_last;
        else gid = req1_valid;
    endtask

    task automatic check_outputs();
        bit gv, gid, er0, er1, erv;
        model_pick(gv, gid);
        if (rst_n !== 1'b1) begin
            er0 = 0; er1 = 0; erv = 0;
        end else begin
            er0 = !m_busy && gv && !gid;
            er1 = !m_busy && gv && gid;
            erv = m_busy && (m_age >= 1);
        end
        chk("req0_ready", W'(req0_ready), W'(er0));
        chk("req1_ready", W'(req1_ready), W'(er1));
        chk("rsp_valid", W'(rsp_valid), W'(erv));
        chk("cmp_a", cmp_a, m_a);
        chk("cmp_b", cmp_b, m_b);
        if (erv) begin
            chk("rsp_eq", W'(rsp_eq), W'(m_eq));
            chk("rsp_id", W'(rsp_id), W'(m_id));
        end
        if (req0_ready === 1'b1) begin obs_g.push_back(0); obs_gt.push_back(cyc); end
        if (req1_ready === 1'b1) begin obs_g.push_back(1); obs_gt.push_back(cyc); end
        if (rsp_valid === 1'b1 && rsp_ready) begin
            obs_rsp.push_back(int'(rsp_id) * 2 + int'(rsp_eq));
            obs_rt.push_back(cyc);
        end
    endtask

    task automatic update_model();
        bit gv, gid;
        model_pick(gv, gid);
        if (rst_n !== 1'b1) model_reset();
        else if (!m_busy) begin
            if (gv) begin
                m_busy = 1; m_age = 0; m_id = gid; m_last = gid;
                m_a = gid ? req1_a : req0_a;
                m_b = gid ? req1_b : req0_b;
                m_eq = (m_a == m_b);
            end
        end else if (m_age == 0) m_age = 1;
        else if (rsp_ready) m_busy = 0;
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled at negedge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_b(input logic [W-1:0] a);
        logic [W-1:0] one;
        one = {{(W-1){1'b0}}, 1'b1};
        case ($urandom_range(2))
            0: return a;
            1: return a ^ (one << $urandom_range(W-1));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int b, br;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_reset();
        #2;
        chk("rst_rsp_eq", W'(rsp_eq), '0);
        chk("rst_rsp_id", W'(rsp_id), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_cmp_a", cmp_a, '0);
        // Requests during reset must not be granted.
        req0_valid = 1; req1_valid = 1;
        cycle();
        cycle();
        req0_valid = 0; req1_valid = 0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single equal compare on requester 0.
        req0_valid = 1; req0_a = 32'h5; req0_b = 32'h5; rsp_ready = 1;
        b = obs_g.size(); br = obs_rsp.size();
        cycle();
        req0_valid = 0;
        repeat (3) cycle();
        chk("single_grant", W'(obs_g[b]), W'(0));
        chk("single_rsp", W'(obs_rsp[br]), W'(1));
        chk("single_latency", W'(obs_rt[br] - obs_gt[b]), W'(2));

        // MSB-only inequality on requester 1.
        req1_valid = 1; req1_a = 32'h8000_0000; req1_b = 32'h0;
        br = obs_rsp.size();
        cycle();
        req1_valid = 0;
        repeat (3) cycle();
        chk("msb_rsp", W'(obs_rsp[br]), W'(2));

        // Continuous tie after reset: alternate starting with requester 0.
        do_reset();
        req0_valid = 1; req0_a = 0; req0_b = 0;
        req1_valid = 1; req1_a = 1; req1_b = 0;
        b = obs_g.size(); br = obs_rsp.size();
        repeat (12) cycle();
        req0_valid = 0; req1_valid = 0;
        cycle();
        chk("tie_ngrants", W'(obs_g.size() - b), W'(4));
        for (int i = 0; i < 4; i++) begin
            chk("tie_order", W'(obs_g[b+i]), W'(i % 2));
            chk("tie_rsp", W'(obs_rsp[br+i]), W'((i % 2) ? 2 : 1));
            if (i > 0) chk("tie_spacing", W'(obs_gt[b+i] - obs_gt[b+i-1]), W'(3));
        end

        // Backpressure: 5 stalled RSP cycles with requester 1 waiting.
        req0_valid = 1; req0_a = 3; req0_b = 3; rsp_ready = 0;
        b = obs_g.size(); br = obs_rsp.size();
        cycle();
        req0_valid = 0; req1_valid = 1; req1_a = 7; req1_b = 9;
        repeat (6) cycle();
        rsp_ready = 1;
        cycle();
        cycle();
        req1_valid = 0;
        repeat (3) cycle();
        chk("bp_rsp", W'(obs_rsp[br]), W'(1));
        chk("bp_stall", W'(obs_rt[br] - obs_gt[b]), W'(7));
        chk("bp_next_grant", W'(obs_gt[b+1] - obs_rt[br]), W'(1));

        // Reset during CMP discards the compare.
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        br = obs_rsp.size();
        cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_cmp_a", cmp_a, '0);
        chk("mid_rst_cmp_b", cmp_b, '0);
        chk("mid_rst_ready", W'(req0_ready), '0);
        chk("mid_rst_rsp_valid", W'(rsp_valid), '0);
        chk("mid_rst_rsp_eq", W'(rsp_eq), '0);
        @(posedge clk); #1; cyc++;
        cycle();
        req0_valid = 0;
        rst_n = 1'b1;
        repeat (4) cycle();
        chk("mid_rst_no_rsp", W'(obs_rsp.size() - br), '0);
        req0_valid = 1; req0_a = 1; req0_b = 2; req1_valid = 1; req1_a = 4; req1_b = 4;
        b = obs_g.size();
        cycle();
        req0_valid = 0; req1_valid = 0;
        repeat (3) cycle();
        chk("mid_rst_tie", W'(obs_g[b]), W'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(3) != 0);
            req1_valid = ($urandom_range(3) != 0);
            req0_a = W'($urandom); req0_b = rnd_b(req0_a);
            req1_a = W'($urandom); req1_b = rnd_b(req1_a);
            rsp_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
